// File: rtl/time_display_scanner_if.sv
// time_display_scanner_if
// Bundles the capture handshake and the multiplexed display drive of the
// time display scanner.
//   load     : single-cycle strobe, samples min_in/sec_in
//   min_in   : minutes, binary 0..127
//   sec_in   : seconds, binary 0..127
//   colon_en : lights the decimal point on digit 2
//   busy     : conversion in progress
//   done     : one-cycle pulse when new digits are committed
//   seg      : segments {g,f,e,d,c,b,a}, active-low
//   dp       : decimal point, active-low
//   an       : digit enables, active-low
// The master modport is the time counter / board side, the slave modport
// is the scanner itself.
interface time_display_scanner_if;
  logic       load;
  logic [6:0] min_in;
  logic [6:0] sec_in;
  logic       colon_en;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output load, min_in, sec_in, colon_en,
    input  busy, done, seg, dp, an
  );

  modport slave (
    input  load, min_in, sec_in, colon_en,
    output busy, done, seg, dp, an
  );
endinterface

// File: rtl/time_display_scanner.sv
// time_display_scanner
// Captures binary minutes/seconds on a load strobe, converts both to two
// BCD digits each with a sequential shift-add-3 engine, and drives a
// 4-digit multiplexed common-anode seven-segment display. Values above 99
// are shown as dashes.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : time_display_scanner_if.slave (load/min_in/sec_in/colon_en in,
//         busy/done/seg/dp/an out)
// Parameter:
//   SCAN_DIV : clock cycles per digit scan slot (>= 4)
module time_display_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input logic clk,
  input logic rst,
  time_display_scanner_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DASH = 4'hA;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t          state;
  logic [6:0]      min_val, sec_val;
  logic [6:0]      min_sh, sec_sh;
  logic [6:0]      pend_min, pend_sec;
  logic            pending;
  logic [7:0]      min_bcd, sec_bcd;
  logic [2:0]      iter;
  logic [3:0][3:0] digits;
  logic            busy_r, done_r;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       an_r;
  logic             blank;

  // Where the next conversion takes its operands when leaving COMMIT:
  // a load arriving in the COMMIT cycle is newer than anything pending.
  logic [6:0] next_min, next_sec;

  assign next_min = bus.load ? bus.min_in : pend_min;
  assign next_sec = bus.load ? bus.sec_in : pend_sec;

  // One double-dabble iteration: correct both nibbles, then shift the
  // next binary bit in. The hundreds carry is dropped on purpose; values
  // that need it are replaced by dashes at commit time.
  function automatic logic [7:0] dabble_step(input logic [7:0] bcd,
                                              input logic bit_in);
    logic [7:0] adj;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    return {adj[6:0], bit_in};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b0111111;
    endcase
  endfunction

  // Capture/convert FSM. Display digits are only written in COMMIT so the
  // scanner never shows a half-converted value. Loads seen while busy go
  // into a single pending slot, newest wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      min_val  <= '0;
      sec_val  <= '0;
      min_sh   <= '0;
      sec_sh   <= '0;
      pend_min <= '0;
      pend_sec <= '0;
      pending  <= 1'b0;
      min_bcd  <= '0;
      sec_bcd  <= '0;
      iter     <= '0;
      digits   <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            min_val <= bus.min_in;
            sec_val <= bus.sec_in;
            min_sh  <= bus.min_in;
            sec_sh  <= bus.sec_in;
            min_bcd <= '0;
            sec_bcd <= '0;
            iter    <= '0;
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.load) begin
            pend_min <= bus.min_in;
            pend_sec <= bus.sec_in;
            pending  <= 1'b1;
          end
          min_bcd <= dabble_step(min_bcd, min_sh[6]);
          sec_bcd <= dabble_step(sec_bcd, sec_sh[6]);
          min_sh  <= {min_sh[5:0], 1'b0};
          sec_sh  <= {sec_sh[5:0], 1'b0};
          iter    <= iter + 3'd1;
          if (iter == 3'd6) state <= COMMIT;
        end
        COMMIT: begin
          digits[0] <= (sec_val > 7'd99) ? DASH : sec_bcd[3:0];
          digits[1] <= (sec_val > 7'd99) ? DASH : sec_bcd[7:4];
          digits[2] <= (min_val > 7'd99) ? DASH : min_bcd[3:0];
          digits[3] <= (min_val > 7'd99) ? DASH : min_bcd[7:4];
          done_r    <= 1'b1;
          if (bus.load || pending) begin
            min_val <= next_min;
            sec_val <= next_sec;
            min_sh  <= next_min;
            sec_sh  <= next_sec;
            min_bcd <= '0;
            sec_bcd <= '0;
            iter    <= '0;
            pending <= 1'b0;
            state   <= SHIFT;
          end else begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign blank = (div_cnt == DIV_LAST);

  // Display scan. The last divider cycle of every slot is blanked so the
  // previous digit's segments do not ghost onto the next anode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
      seg_r   <= 7'b1111111;
      dp_r    <= 1'b1;
      an_r    <= 4'b1111;
    end else begin
      an_r  <= blank ? 4'b1111 : ~(4'b0001 << idx);
      seg_r <= blank ? 7'b1111111 : seg_code(digits[idx]);
      dp_r  <= ~((idx == 2'd2) && bus.colon_en && !blank);
      if (blank) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.seg  = seg_r;
  assign bus.dp   = dp_r;
  assign bus.an   = an_r;

endmodule

// File: tb/tb_time_display_scanner.sv
// tb_time_display_scanner
// Directed bench for time_display_scanner with SCAN_DIV = 4. Expected
// values are hand-derived segment codes and cycle counts.
module tb_time_display_scanner;

  localparam int SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;

  logic clk;
  logic rst;
  int   check_count;
  int   pass_count;

  time_display_scanner_if bus ();

  time_display_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a load for exactly one edge (the load edge, E0).
  task automatic applyStimulus(input logic [6:0] m, input logic [6:0] s);
    bus.load   = 1'b1;
    bus.min_in = m;
    bus.sec_in = s;
    tick();
    bus.load   = 1'b0;
  endtask

  // Returns the number of edges after E0 at which done was first seen,
  // or 0 if it never came within the budget.
  task automatic waitDone(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Scans until all four enabled slots were observed and returns their seg.
  task automatic readDisplay(output logic [6:0] d0, output logic [6:0] d1,
                             output logic [6:0] d2, output logic [6:0] d3);
    logic [3:0] seen;
    seen = 4'b0000;
    d0 = 'x; d1 = 'x; d2 = 'x; d3 = 'x;
    for (int c = 0; c < 8 * SCAN_DIV && seen != 4'b1111; c++) begin
      tick();
      case (bus.an)
        4'b1110: begin d0 = bus.seg; seen[0] = 1'b1; end
        4'b1101: begin d1 = bus.seg; seen[1] = 1'b1; end
        4'b1011: begin d2 = bus.seg; seen[2] = 1'b1; end
        4'b0111: begin d3 = bus.seg; seen[3] = 1'b1; end
        default: ;
      endcase
    end
    checkOutput("scan_all_slots", {28'd0, seen}, 32'hF);
  endtask

  task automatic checkDisplay(input string tag, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2,
                              input logic [6:0] e3);
    logic [6:0] d0, d1, d2, d3;
    readDisplay(d0, d1, d2, d3);
    checkOutput({tag, "_an0"}, {25'd0, d0}, {25'd0, e0});
    checkOutput({tag, "_an1"}, {25'd0, d1}, {25'd0, e1});
    checkOutput({tag, "_an2"}, {25'd0, d2}, {25'd0, e2});
    checkOutput({tag, "_an3"}, {25'd0, d3}, {25'd0, e3});
  endtask

  initial begin
    int         cyc;
    int         done_cnt;
    int         first_done;
    int         second_done;
    int         slot_hits;
    logic [3:0] exp_an;

    check_count  = 0;
    pass_count   = 0;
    rst          = 1'b0;
    bus.load     = 1'b0;
    bus.min_in   = '0;
    bus.sec_in   = '0;
    bus.colon_en = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_seg",  {25'd0, bus.seg}, {25'd0, 7'b1111111});
    checkOutput("rst_dp",   {31'd0, bus.dp}, 32'd1);
    checkOutput("rst_an",   {28'd0, bus.an}, 32'hF);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Idle scan: three enabled cycles then one blank per slot, all zeros
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_an = ((k % 4) == 3) ? 4'b1111 : ~(4'b0001 << ((k / 4) % 4));
      checkOutput($sformatf("idle_an_%0d", k), {28'd0, bus.an}, {28'd0, exp_an});
      if (exp_an != 4'b1111)
        checkOutput($sformatf("idle_seg_%0d", k), {25'd0, bus.seg}, {25'd0, S0});
      checkOutput($sformatf("idle_dp_%0d", k), {31'd0, bus.dp}, 32'd1);
    end
    checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);

    // 12:59 conversion latency and digits
    applyStimulus(7'd12, 7'd59);
    checkOutput("conv_busy_e0", {31'd0, bus.busy}, 32'd1);
    waitDone(cyc);
    checkOutput("conv_done_latency", cyc, 32'd8);
    checkOutput("conv_busy_after", {31'd0, bus.busy}, 32'd0);
    tick();
    checkOutput("conv_done_pulse", {31'd0, bus.done}, 32'd0);
    checkDisplay("d1259", S9, S5, S2, S1);

    // Pending slot: 59:59, then 00:07, then 03:04 overwrites it
    applyStimulus(7'd59, 7'd59);
    tick();
    tick();
    applyStimulus(7'd0, 7'd7);
    applyStimulus(7'd3, 7'd4);
    done_cnt    = 0;
    first_done  = 0;
    second_done = 0;
    for (int c = 5; c <= 30; c++) begin
      tick();
      if (c == 8) checkOutput("pend_busy_held", {31'd0, bus.busy}, 32'd1);
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
        else second_done = c;
      end
    end
    checkOutput("pend_done_count", done_cnt, 32'd2);
    checkOutput("pend_first_done", first_done, 32'd8);
    checkOutput("pend_second_done", second_done, 32'd16);
    checkDisplay("d0304", S4, S0, S3, S0);

    // Out of range values show dashes, then back to 00:00
    applyStimulus(7'd127, 7'd100);
    waitDone(cyc);
    checkOutput("dash_done_latency", cyc, 32'd8);
    checkDisplay("ddash", SD, SD, SD, SD);
    applyStimulus(7'd0, 7'd0);
    waitDone(cyc);
    checkOutput("zero_done_latency", cyc, 32'd8);
    checkDisplay("d0000", S0, S0, S0, S0);

    // Colon: dp low only while digit 2 is enabled
    bus.colon_en = 1'b1;
    tick();
    slot_hits = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bus.an == 4'b1011) slot_hits++;
      checkOutput($sformatf("colon_dp_%0d", k), {31'd0, bus.dp},
                  (bus.an == 4'b1011) ? 32'd0 : 32'd1);
    end
    checkOutput("colon_slot_seen", slot_hits, 32'd3);
    bus.colon_en = 1'b0;

    // Reset mid-conversion aborts it
    applyStimulus(7'd45, 7'd30);
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_seg",  {25'd0, bus.seg}, {25'd0, 7'b1111111});
    checkOutput("abort_an",   {28'd0, bus.an}, 32'hF);
    checkOutput("abort_dp",   {31'd0, bus.dp}, 32'd1);
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("abort_first_an", {28'd0, bus.an}, 32'hE);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    checkOutput("abort_no_done", done_cnt, 32'd0);
    checkDisplay("dabort", S0, S0, S0, S0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
